// File: rtl/cnet_reg_arb_if.sv
// cnet_reg_arb_if
//   Bundles the two requester ports and the CNET register bus seen by
//   cnet_reg_arb.
//   slave  : arbiter side (takes requests and CNET responses, drives CNET and completions)
//   master : requester / CNET-model side
//   req0_* : PCI target register path
//   req1_* : DMA engine register port
//   cnet_* : shared CNET register bus
//   busy   : arbiter not idle
interface cnet_reg_arb_if #(
   parameter int ADDR_W = 22
);
   logic              req0_valid;
   logic              req0_rd_wr_l;
   logic [ADDR_W-1:0] req0_addr;
   logic [31:0]       req0_wr_data;
   logic              req0_done;
   logic              req0_timeout;
   logic [31:0]       req0_rd_data;

   logic              req1_valid;
   logic              req1_rd_wr_l;
   logic [ADDR_W-1:0] req1_addr;
   logic [31:0]       req1_wr_data;
   logic              req1_done;
   logic              req1_timeout;
   logic [31:0]       req1_rd_data;

   logic              cnet_req;
   logic              cnet_rd_wr_l;
   logic [ADDR_W-1:0] cnet_addr;
   logic [31:0]       cnet_wr_data;
   logic              cnet_ack;
   logic [31:0]       cnet_rd_data;

   logic              busy;

   modport slave (
      input  req0_valid, req0_rd_wr_l, req0_addr, req0_wr_data,
      output req0_done, req0_timeout, req0_rd_data,
      input  req1_valid, req1_rd_wr_l, req1_addr, req1_wr_data,
      output req1_done, req1_timeout, req1_rd_data,
      output cnet_req, cnet_rd_wr_l, cnet_addr, cnet_wr_data,
      input  cnet_ack, cnet_rd_data,
      output busy
   );

   modport master (
      output req0_valid, req0_rd_wr_l, req0_addr, req0_wr_data,
      input  req0_done, req0_timeout, req0_rd_data,
      output req1_valid, req1_rd_wr_l, req1_addr, req1_wr_data,
      input  req1_done, req1_timeout, req1_rd_data,
      input  cnet_req, cnet_rd_wr_l, cnet_addr, cnet_wr_data,
      output cnet_ack, cnet_rd_data,
      input  busy
   );
endinterface

// File: rtl/cnet_reg_arb.sv
// cnet_reg_arb
//   Round-robin arbiter and sequencer sharing the CNET register bus between
//   the PCI target path (req0) and the DMA register port (req1). One access at
//   a time, ack wait bounded by TIMEOUT_CYCLES, completion returned to the
//   granted requester only.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cnet_reg_arb_if.slave (requester ports, CNET bus, busy)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a request; winner's fields latched onto cnet_*
//   S_ISSUE | raise cnet_req, clear ack timer
//   S_WAIT  | cnet_req high; waiting for cnet_ack or timer terminal count
//   S_DONE  | done pulse visible to the granted requester; grant recorded
//   S_GAP   | one idle bus cycle before arbitrating again
module cnet_reg_arb #(
   parameter int          ADDR_W         = 22,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic           clk,
   input  logic           rst_n,
   cnet_reg_arb_if.slave  bus
);

   localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_GAP
   } state_t;

   state_t             state, state_nxt;
   logic               last_grant;
   logic               grant;
   logic [TMR_W-1:0]   timer;

   logic               any_valid;
   logic               pick;
   logic               sel_rd_wr_l;
   logic [ADDR_W-1:0]  sel_addr;
   logic [31:0]        sel_wr_data;
   logic               timer_tc;
   logic               acc_end;
   logic               acc_tmo;
   logic [31:0]        acc_data;

   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      // On a tie the requester that did not win last time gets the bus.
      pick = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
      sel_rd_wr_l = pick ? bus.req1_rd_wr_l : bus.req0_rd_wr_l;
      sel_addr    = pick ? bus.req1_addr    : bus.req0_addr;
      sel_wr_data = pick ? bus.req1_wr_data : bus.req0_wr_data;

      timer_tc = (timer == TMR_LAST);
      acc_end  = (state == S_WAIT) & (bus.cnet_ack | timer_tc);
      // An ack on the terminal-count cycle still counts as a normal completion.
      acc_tmo  = ~bus.cnet_ack;
      if (!bus.cnet_rd_wr_l) begin
         acc_data = '0;
      end else if (bus.cnet_ack) begin
         acc_data = bus.cnet_rd_data;
      end else begin
         acc_data = TIMEOUT_DATA;
      end

      state_nxt = state;
      case (state)
         S_IDLE:  if (any_valid) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (acc_end) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_GAP;
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant       <= 1'b1;
         grant            <= 1'b0;
         timer            <= '0;
         bus.cnet_req     <= 1'b0;
         bus.cnet_rd_wr_l <= 1'b0;
         bus.cnet_addr    <= '0;
         bus.cnet_wr_data <= '0;
         bus.req0_done    <= 1'b0;
         bus.req0_timeout <= 1'b0;
         bus.req0_rd_data <= '0;
         bus.req1_done    <= 1'b0;
         bus.req1_timeout <= 1'b0;
         bus.req1_rd_data <= '0;
      end else begin
         bus.req0_done <= 1'b0;
         bus.req1_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  grant            <= pick;
                  bus.cnet_rd_wr_l <= sel_rd_wr_l;
                  bus.cnet_addr    <= sel_addr;
                  bus.cnet_wr_data <= sel_wr_data;
               end
            end
            S_ISSUE: begin
               bus.cnet_req <= 1'b1;
               timer        <= '0;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               // Completion registers load on the exit edge so done, timeout
               // and rd_data all appear together in the DONE cycle.
               if (acc_end) begin
                  bus.cnet_req <= 1'b0;
                  if (grant) begin
                     bus.req1_done    <= 1'b1;
                     bus.req1_timeout <= acc_tmo;
                     bus.req1_rd_data <= acc_data;
                  end else begin
                     bus.req0_done    <= 1'b1;
                     bus.req0_timeout <= acc_tmo;
                     bus.req0_rd_data <= acc_data;
                  end
               end
            end
            S_DONE: begin
               last_grant <= grant;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_cnet_reg_arb.sv
module tb_cnet_reg_arb;

   localparam int          TC     = 16;
   localparam logic [31:0] TO_DAT = 32'hDEAD_BEEF;

   logic clk;
   logic rst_n;

   cnet_reg_arb_if #(.ADDR_W(22)) bus ();

   cnet_reg_arb #(
      .ADDR_W         (22),
      .TIMEOUT_CYCLES (TC),
      .TIMEOUT_DATA   (TO_DAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          v0, v1, rd0, rd1;
      logic [21:0] a0, a1;
      logic [31:0] w0, w1;
      int          ack_at;     // WAIT-cycle index of the ack, -1 = never
      logic [31:0] ack_data;
      bit          hold, stray;
      bit          eg, etmo;
      logic [31:0] erd;
      int          ecyc;       // cycles cnet_req stays high
   } vec_t;

   vec_t        vecs [12];
   int          checks;
   int          failures;
   bit          mdl_last;
   logic [31:0] mdl_rd [2];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   function automatic logic [10:0] out_bits();
      return {bus.req0_done, bus.req1_done, bus.req0_timeout, bus.req1_timeout,
              bus.busy, bus.cnet_req, bus.cnet_rd_wr_l,
              |bus.req0_rd_data, |bus.req1_rd_data, |bus.cnet_addr, |bus.cnet_wr_data};
   endfunction

   // Entered in an IDLE cycle just after a clock edge; returns in the next IDLE cycle.
   task automatic run_access(input vec_t v);
      int          k, kf, kd, n0, n1, nreq;
      logic [54:0] exp_fields;
      bus.req0_valid   = v.v0;  bus.req0_rd_wr_l = v.rd0;
      bus.req0_addr    = v.a0;  bus.req0_wr_data = v.w0;
      bus.req1_valid   = v.v1;  bus.req1_rd_wr_l = v.rd1;
      bus.req1_addr    = v.a1;  bus.req1_wr_data = v.w1;
      bus.cnet_ack     = v.stray;
      bus.cnet_rd_data = $urandom;
      exp_fields = v.eg ? {v.rd1, v.a1, v.w1} : {v.rd0, v.a0, v.w0};
      k = 0; kf = -1; kd = -1; n0 = 0; n1 = 0; nreq = 0;
      while (k < 60) begin
         @(posedge clk); #1;
         k++;
         if (bus.req0_done === 1'b1) n0++;
         if (bus.req1_done === 1'b1) n1++;
         if (bus.cnet_req === 1'b1) begin
            nreq++;
            if (kf < 0) begin
               kf = k;
               chk("cnet_fields", 64'({bus.cnet_rd_wr_l, bus.cnet_addr, bus.cnet_wr_data}),
                   64'(exp_fields));
            end
         end
         if (kd < 0 && (bus.req0_done === 1'b1 || bus.req1_done === 1'b1)) begin
            kd = k;
            chk("done_grant", 64'({bus.req1_done, bus.req0_done}), 64'(v.eg ? 2'b10 : 2'b01));
            chk("timeout", 64'(v.eg ? bus.req1_timeout : bus.req0_timeout), 64'(v.etmo));
            chk("rd_data", 64'(v.eg ? bus.req1_rd_data : bus.req0_rd_data), 64'(v.erd));
            chk("other_rd_data", 64'(v.eg ? bus.req0_rd_data : bus.req1_rd_data),
                64'(mdl_rd[!v.eg]));
            if (!v.hold) begin
               if (v.eg) bus.req1_valid = 1'b0;
               else      bus.req0_valid = 1'b0;
            end
         end
         if (kd >= 0 && k == kd + 2) break;
         if (bus.cnet_req === 1'b1) bus.cnet_ack = ((k - kf) == v.ack_at);
         else                       bus.cnet_ack = v.stray;
         bus.cnet_rd_data = bus.cnet_ack ? v.ack_data : $urandom;
      end
      bus.cnet_ack = 1'b0;
      if (kd < 0) begin
         chk("done_seen", 64'(0), 64'(1));
      end else begin
         chk("latency", 64'(kd), 64'(v.ecyc + 2));
         chk("req_cycles", 64'(nreq), 64'(v.ecyc));
         chk("done_pulses", 64'(n0 + n1), 64'(1));
         chk("busy_idle", 64'(bus.busy), 64'(0));
         chk("rd_data_held", 64'(v.eg ? bus.req1_rd_data : bus.req0_rd_data), 64'(v.erd));
      end
      mdl_rd[v.eg] = v.erd;
      mdl_last     = v.eg;
   endtask

   task automatic clear_inputs();
      bus.req0_valid = 1'b0; bus.req0_rd_wr_l = 1'b0; bus.req0_addr = '0; bus.req0_wr_data = '0;
      bus.req1_valid = 1'b0; bus.req1_rd_wr_l = 1'b0; bus.req1_addr = '0; bus.req1_wr_data = '0;
      bus.cnet_ack   = 1'b0; bus.cnet_rd_data = '0;
   endtask

   initial begin
      vec_t rv;
      int   r;
      bit   acked;
      checks = 0; failures = 0;
      mdl_last = 1'b1; mdl_rd[0] = '0; mdl_rd[1] = '0;

      vecs[0]  = '{1,0, 0,0, 22'h40_0008, 22'h0, 32'h0000_000A, 32'h0, 3, 32'hFFFF_0000, 0,0, 0,0, 32'h0, 4};
      vecs[1]  = '{0,1, 0,1, 22'h0, 22'h40_0010, 32'h0, 32'h0, 0, 32'h1234_5678, 0,0, 1,0, 32'h1234_5678, 1};
      vecs[2]  = '{1,1, 1,0, 22'h40_0000, 22'h00_1234, 32'h0, 32'h55AA_55AA, 0, 32'hCAFE_F00D, 1,0, 0,0, 32'hCAFE_F00D, 1};
      vecs[3]  = '{1,1, 1,0, 22'h40_0000, 22'h00_1234, 32'h0, 32'h55AA_55AA, 1, 32'h0BAD_F00D, 1,0, 1,0, 32'h0, 2};
      vecs[4]  = '{1,1, 1,0, 22'h40_0000, 22'h00_1234, 32'h0, 32'h55AA_55AA, 5, 32'h1111_2222, 1,0, 0,0, 32'h1111_2222, 6};
      vecs[5]  = '{1,1, 1,0, 22'h40_0000, 22'h00_1234, 32'h0, 32'h55AA_55AA, 0, 32'h3333_4444, 1,0, 1,0, 32'h0, 1};
      vecs[6]  = '{1,1, 1,0, 22'h40_0000, 22'h00_1234, 32'h0, 32'h55AA_55AA, 2, 32'h5555_6666, 1,0, 0,0, 32'h5555_6666, 3};
      vecs[7]  = '{1,1, 1,0, 22'h40_0000, 22'h00_1234, 32'h0, 32'h55AA_55AA, 0, 32'h7777_8888, 1,0, 1,0, 32'h0, 1};
      vecs[8]  = '{1,0, 1,0, 22'h40_0004, 22'h0, 32'h0, 32'h0, -1, 32'h0, 0,0, 0,1, 32'hDEAD_BEEF, 16};
      vecs[9]  = '{0,1, 0,1, 22'h0, 22'h3F_FFFC, 32'h0, 32'h0, 15, 32'h600D_CAFE, 0,1, 1,0, 32'h600D_CAFE, 16};
      vecs[10] = '{0,1, 0,0, 22'h0, 22'h12_3450, 32'h0, 32'h8765_4321, -1, 32'h0, 0,1, 1,1, 32'h0, 16};
      vecs[11] = '{1,1, 0,1, 22'h2A_AAA8, 22'h15_5554, 32'hA5A5_A5A5, 32'h0, 4, 32'h9999_9999, 0,1, 0,0, 32'h0, 5};

      rst_n = 1'b0;
      clear_inputs();
      #12;
      chk("reset_outputs", 64'(out_bits()), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_access(vecs[i]);
      clear_inputs();

      // Stray acks while idle must not produce a completion.
      for (int i = 0; i < 3; i++) begin
         bus.cnet_ack = 1'b1; bus.cnet_rd_data = $urandom;
         @(posedge clk); #1;
         chk("idle_stray_ack", 64'({bus.req0_done, bus.req1_done, bus.busy, bus.cnet_req}), 64'(0));
      end
      bus.cnet_ack = 1'b0;

      // Reset in the middle of a WAIT; last grant was req0, so a fresh tie must still go to req0.
      bus.req1_valid = 1'b1; bus.req1_rd_wr_l = 1'b1; bus.req1_addr = 22'h40_0020;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_wait", 64'({bus.cnet_req, bus.busy}), 64'(2'b11));
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 64'(out_bits()), 64'(0));
      clear_inputs();
      @(negedge clk) rst_n = 1'b1;
      mdl_last = 1'b1; mdl_rd[0] = '0; mdl_rd[1] = '0;
      @(posedge clk); #1;
      chk("post_reset_no_done", 64'({bus.req0_done, bus.req1_done, bus.busy}), 64'(0));
      rv = '{1,1, 1,1, 22'h40_0030, 22'h40_0034, 32'h0, 32'h0, 0, 32'h0A0B_0C0D, 0,0, 0,0, 32'h0A0B_0C0D, 1};
      run_access(rv);

      // Random traffic against the transaction-level model.
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(1, 3));
         rv.v0 = r[0]; rv.v1 = r[1];
         rv.rd0 = 1'($urandom); rv.rd1 = 1'($urandom);
         rv.a0 = 22'($urandom); rv.a1 = 22'($urandom);
         rv.w0 = $urandom; rv.w1 = $urandom;
         r = int'($urandom_range(0, 19));
         rv.ack_at = (r < TC) ? r : -1;
         rv.ack_data = $urandom;
         rv.hold = 1'($urandom); rv.stray = 1'($urandom);
         rv.eg = (rv.v0 && rv.v1) ? !mdl_last : rv.v1;
         acked = (rv.ack_at >= 0);
         rv.etmo = !acked;
         rv.ecyc = acked ? rv.ack_at + 1 : TC;
         if (!(rv.eg ? rv.rd1 : rv.rd0)) rv.erd = 32'h0;
         else if (acked)                 rv.erd = rv.ack_data;
         else                            rv.erd = TO_DAT;
         run_access(rv);
      end
      clear_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
